operand_fetch_unit: RTL and testbench

OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

---
 rtl/lite16_pkg.sv | 26 ++
 rtl/reg_read_mux.sv | 23 ++
 rtl/operand_fetch_unit.sv | 128 ++++++++++++
 tb/tb_operand_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lite16_pkg.sv
// Shared lite16 definitions: register geometry, flat-bus slicing and the
// operand-fetch buffer entry layout.
package lite16_pkg;

    localparam int unsigned REG_WIDTH       = 16;
    localparam int unsigned REG_INDEX_WIDTH = 4;
    localparam int unsigned REG_COUNT       = 16;
    localparam int unsigned TAG_WIDTH       = 4;

    typedef logic [REG_WIDTH-1:0]       reg_t;
    typedef logic [REG_INDEX_WIDTH-1:0] reg_idx_t;
    typedef logic [TAG_WIDTH-1:0]       tag_t;

    // One buffered fetch result: both operands plus the caller's tag.
    typedef struct packed {
        reg_t op1;
        reg_t op2;
        tag_t tag;
    } fetch_entry_t;

    // Register i occupies bits [i*REG_WIDTH +: REG_WIDTH] of the flat bus.
    function automatic int unsigned slice_lsb(input int unsigned idx);
        return idx * REG_WIDTH;
    endfunction

endpackage

// File: rtl/reg_read_mux.sv
// Combinational register read port: selects one register out of the flat
// register-file bus.
module reg_read_mux
    import lite16_pkg::*;
#(
    parameter int unsigned REGISTER_COUNT = 16
) (
    input  logic [REGISTER_COUNT*REG_WIDTH-1:0] rf_data,
    input  logic [REG_INDEX_WIDTH-1:0]          sel,
    output logic [REG_WIDTH-1:0]                data
);

    // Decode the index and pick the matching slice; unmatched indices read 0.
    always_comb begin
        data = '0;
        for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
            if (sel == REG_INDEX_WIDTH'(i)) begin
                data = rf_data[slice_lsb(i) +: REG_WIDTH];
            end
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: reads two source registers (with same-cycle write
// bypass) and queues the snapshot in a two-entry FIFO toward the consumer.
// The head entry is held in a dedicated output register so the outputs keep
// the last popped values while the buffer is empty.
module operand_fetch_unit
    import lite16_pkg::*;
#(
    parameter int unsigned REGISTER_COUNT = 16,
    parameter int unsigned DEPTH          = 2   // only 2 is supported
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [REG_INDEX_WIDTH-1:0]          req_rs1,
    input  logic [REG_INDEX_WIDTH-1:0]          req_rs2,
    input  logic [TAG_WIDTH-1:0]                req_tag,
    input  logic [REGISTER_COUNT*REG_WIDTH-1:0] rf_data,
    input  logic [REGISTER_COUNT-1:0]           wr_en,
    input  logic [REG_WIDTH-1:0]                wr_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [REG_WIDTH-1:0]                out_op1,
    output logic [REG_WIDTH-1:0]                out_op2,
    output logic [TAG_WIDTH-1:0]                out_tag,
    output logic [15:0]                         fetch_count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    fetch_entry_t head_q, head_d;
    fetch_entry_t new_entry;
    logic [1:0]   count_q, count_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         ready_q, ready_d;
    logic [15:0]  fetch_count_q, fetch_count_d;
    logic [REG_WIDTH-1:0] rs1_rf, rs2_rf;
    logic         push, pop;

    reg_read_mux #(
        .REGISTER_COUNT(REGISTER_COUNT)
    ) u_rs1_mux (
        .rf_data(rf_data),
        .sel    (req_rs1),
        .data   (rs1_rf)
    );

    reg_read_mux #(
        .REGISTER_COUNT(REGISTER_COUNT)
    ) u_rs2_mux (
        .rf_data(rf_data),
        .sel    (req_rs2),
        .data   (rs2_rf)
    );

    assign push = req_valid & ready_q;
    assign pop  = out_valid & out_ready;

    // Build the entry to capture, bypassing any write landing this cycle.
    always_comb begin
        new_entry     = '0;
        new_entry.op1 = wr_en[req_rs1] ? wr_data : rs1_rf;
        new_entry.op2 = wr_en[req_rs2] ? wr_data : rs2_rf;
        new_entry.tag = req_tag;
    end

    // FIFO bookkeeping; the head register tracks the post-edge oldest entry
    // and simply holds when the buffer drains.
    always_comb begin
        mem_d         = mem_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fetch_count_d = fetch_count_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
            fetch_count_d   = fetch_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Registered so req_ready never depends combinationally on out_ready.
        ready_d = (count_d < FULL_COUNT);
        head_d  = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]      <= '0;
            mem_q[1]      <= '0;
            head_q        <= '0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            ready_q       <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            mem_q         <= mem_d;
            head_q        <= head_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            ready_q       <= ready_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign req_ready   = ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_op1     = head_q.op1;
    assign out_op2     = head_q.op2;
    assign out_tag     = head_q.tag;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit.
module tb_operand_fetch_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_rs1, req_rs2, req_tag;
    logic [255:0] rf_data;
    logic [15:0]  wr_en;
    logic [15:0]  wr_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_op1, out_op2;
    logic [3:0]   out_tag;
    logic [15:0]  fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch_unit #(
        .REGISTER_COUNT(16),
        .DEPTH         (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .rf_data    (rf_data),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_tag    (out_tag),
        .fetch_count(fetch_count)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [15:0] val);
        rf_data[idx*16 +: 16] = val;
    endtask

    function automatic logic [15:0] rf_get(input int idx);
        return rf_data[idx*16 +: 16];
    endfunction

    task automatic drive_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] tag);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
    endtask

    initial begin
        int good;
        logic [3:0] tag_i;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        rf_data   = '0;
        wr_en     = '0;
        wr_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        check("rst_op1", 32'(out_op1), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Basic fetch, latency 1
        set_reg(3, 16'h1234);
        set_reg(7, 16'hBEEF);
        drive_req(4'd3, 4'd7, 4'd5);
        step();
        req_valid = 1'b0;
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_op1", 32'(out_op1), 32'h1234);
        check("basic_op2", 32'(out_op2), 32'hBEEF);
        check("basic_tag", 32'(out_tag), 32'd5);
        check("basic_count", 32'(fetch_count), 32'd1);
        step();
        check("stall_tag", 32'(out_tag), 32'd5);
        check("stall_op1", 32'(out_op1), 32'h1234);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_hold_op1", 32'(out_op1), 32'h1234);

        // Write bypass, same register on both operands
        wr_en   = 16'h0008;
        wr_data = 16'hAAAA;
        drive_req(4'd3, 4'd3, 4'd6);
        step();
        req_valid = 1'b0;
        wr_en     = '0;
        check("bypass_op1", 32'(out_op1), 32'hAAAA);
        check("bypass_op2", 32'(out_op2), 32'hAAAA);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Non-one-hot write enable: only the matching bit bypasses
        wr_en   = 16'h0081;
        wr_data = 16'h5555;
        drive_req(4'd7, 4'd3, 4'd7);
        step();
        req_valid = 1'b0;
        wr_en     = '0;
        check("multi_bypass_op1", 32'(out_op1), 32'h5555);
        check("multi_bypass_op2", 32'(out_op2), 32'h1234);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Backpressure: third request refused, order preserved
        set_reg(1, 16'h1111);
        set_reg(2, 16'h2222);
        set_reg(4, 16'h4444);
        drive_req(4'd1, 4'd0, 4'd1);
        step();
        check("bp_ready_after_1", 32'(req_ready), 32'd1);
        drive_req(4'd2, 4'd0, 4'd2);
        step();
        check("bp_ready_after_2", 32'(req_ready), 32'd0);
        drive_req(4'd4, 4'd0, 4'd3);
        step();
        req_valid = 1'b0;
        check("bp_ready_third", 32'(req_ready), 32'd0);
        check("bp_count", 32'(fetch_count), 32'd5);
        check("bp_head_tag", 32'(out_tag), 32'd1);
        check("bp_head_op1", 32'(out_op1), 32'h1111);
        out_ready = 1'b1;
        step();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_tag", 32'(out_tag), 32'd2);
        check("bp_second_op1", 32'(out_op1), 32'h2222);
        check("bp_ready_reopen", 32'(req_ready), 32'd1);
        step();
        out_ready = 1'b0;
        check("bp_empty", 32'(out_valid), 32'd0);

        // Snapshot: a later write must not alter a buffered entry
        set_reg(2, 16'h0001);
        drive_req(4'd2, 4'd2, 4'd8);
        step();
        req_valid = 1'b0;
        set_reg(2, 16'h0002);
        wr_en   = 16'h0004;
        wr_data = 16'h0002;
        step();
        wr_en = '0;
        check("snap_op1", 32'(out_op1), 32'h0001);
        check("snap_tag", 32'(out_tag), 32'd8);
        drive_req(4'd2, 4'd2, 4'd9);
        step();
        req_valid = 1'b0;
        check("snap_full_ready", 32'(req_ready), 32'd0);
        check("snap_head_kept", 32'(out_op1), 32'h0001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("snap_next_op1", 32'(out_op1), 32'h0002);
        check("snap_next_tag", 32'(out_tag), 32'd9);
        drive_req(4'd2, 4'd2, 4'd10);
        step();
        req_valid = 1'b0;
        check("snap_refull_ready", 32'(req_ready), 32'd0);
        check("snap_count", 32'(fetch_count), 32'd8);

        // Asynchronous reset with two entries buffered
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(fetch_count), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_op1", 32'(out_op1), 32'd0);
        check("async_rst_tag", 32'(out_tag), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rerst_ready", 32'(req_ready), 32'd1);
        check("rerst_no_entry", 32'(out_valid), 32'd0);

        // Streaming: one request per cycle, no bubbles
        out_ready = 1'b1;
        good = 0;
        for (int i = 0; i < 100; i++) begin
            tag_i = 4'(i);
            drive_req(4'(i % 16), 4'(15 - (i % 16)), tag_i);
            step();
            if (out_valid === 1'b1 && out_tag === tag_i &&
                out_op1 === rf_get(i % 16) && out_op2 === rf_get(15 - (i % 16))) begin
                good++;
            end
        end
        req_valid = 1'b0;
        check("stream_outputs", 32'(good), 32'd100);
        check("stream_count", 32'(fetch_count), 32'd100);
        step();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Counter wrap
        req_valid = 1'b1;
        repeat (65435) step();
        check("wrap_ffff", 32'(fetch_count), 32'hFFFF);
        step();
        req_valid = 1'b0;
        check("wrap_zero", 32'(fetch_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
